// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues word-aligned cache requests and extends load data.
// Optional MEM_MISALIGN_CHECK_EN suppresses misaligned halfword/word accesses and flags them.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        pipe_advance,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t      state_q, state_d;
    logic        rd_q, rd_d, wr_q, wr_d, mis_q, mis_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        req, bad;
    logic [3:0]  be_n;
    logic [31:0] wd_n;

    function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    assign req = ex_valid & (ex_mem_read | ex_mem_write);

    always_comb begin
        be_n = 4'b1111;
        wd_n = ex_wdata;
        unique case (ex_funct3[1:0])
            2'b00: begin
                be_n = 4'b0001 << ex_addr[1:0];
                wd_n = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                be_n = 4'b0011 << {ex_addr[1], 1'b0};
                wd_n = {2{ex_wdata[15:0]}};
            end
            default: begin
                be_n = 4'b1111;
                wd_n = ex_wdata;
            end
        endcase
`ifdef MEM_MISALIGN_CHECK_EN
        if (ex_funct3[1:0] == 2'b01)
            bad = ex_addr[0];
        else
            bad = (ex_funct3[1:0] != 2'b00) && (ex_addr[1:0] != 2'b00);
`else
        bad = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        mis_d     = mis_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        be_d      = be_q;
        f3_d      = f3_q;
        off_d     = off_q;
        mem_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    addr_d    = {ex_addr[31:2], 2'b00};
                    off_d     = ex_addr[1:0];
                    f3_d      = ex_funct3;
                    wdata_d   = wd_n;
                    be_d      = ex_mem_write ? be_n : 4'b0000;
                    if (bad) begin
                        mis_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = HOLD;
                    end else begin
                        // write wins when both kinds are flagged
                        wr_d    = ex_mem_write;
                        rd_d    = ~ex_mem_write;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dmem_resp) begin
                    if (rd_q)
                        rdata_d = load_ext(f3_q, off_q, dmem_rdata);
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (pipe_advance) begin
                    mis_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            be_q    <= 4'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    assign dmem_read        = rd_q;
    assign dmem_write       = wr_q;
    assign dmem_address     = addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_byte_enable = be_q;
    assign mem_rdata        = rdata_q;
    assign misalign         = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit.
// Covers loads, stores, HOLD behaviour, reset mid-access and the misalign option.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic        pipe_advance = 1'b0;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    logic        s_rd, s_wr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    int          stalls, reqs;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .pipe_advance(pipe_advance),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one access, answers after dly cycles, returns once the stage stops stalling.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int dly);
        logic prev;
        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
        ex_funct3 = f3; ex_addr = a; ex_wdata = wd; pipe_advance = 1'b0;
        #1;
        stalls = 0; reqs = 0; prev = 1'b0;
        s_rd = 1'b0; s_wr = 1'b0; s_addr = 32'd0; s_wdata = 32'd0; s_be = 4'd0;
        for (int c = 0; c < 12 && mem_stall; c++) begin
            stalls++;
            if ((dmem_read | dmem_write) && !prev) reqs++;
            prev = dmem_read | dmem_write;
            if (c == 1) begin
                s_rd = dmem_read; s_wr = dmem_write; s_addr = dmem_address;
                s_wdata = dmem_wdata; s_be = dmem_byte_enable;
            end
            tick();
            dmem_resp = (c + 1 == dly);
            dmem_rdata = rdat;
            #1;
        end
        dmem_resp = 1'b0;
    endtask

    task automatic advance();
        pipe_advance = 1'b1; ex_valid = 1'b0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        tick();
        pipe_advance = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if ({dmem_read, dmem_write} !== 2'b00) begin errors++;
            $display("FAIL reset_req: got %b exp 00", {dmem_read, dmem_write}); end
        checks++; if (dmem_byte_enable !== 4'd0 || misalign !== 1'b0) begin errors++;
            $display("FAIL reset_be_mis: got %b/%b exp 0000/0", dmem_byte_enable, misalign); end
        checks++; if (dmem_address !== 32'd0 || dmem_wdata !== 32'd0) begin errors++;
            $display("FAIL reset_addr_wdata: got %h/%h exp 0/0", dmem_address, dmem_wdata); end
        checks++; if (mem_rdata !== 32'd0 || mem_stall !== 1'b0) begin errors++;
            $display("FAIL reset_rdata_stall: got %h/%b exp 0/0", mem_rdata, mem_stall); end
    endtask

    task automatic test_lw();
        run(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 3);
        checks++; if (stalls !== 4) begin errors++;
            $display("FAIL lw_stall_cycles: got %0d exp 4", stalls); end
        checks++; if (s_rd !== 1'b1 || s_wr !== 1'b0 || s_addr !== 32'h100) begin errors++;
            $display("FAIL lw_request: got rd=%b wr=%b addr=%h exp 1 0 100", s_rd, s_wr, s_addr); end
        checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL lw_rdata: got %h exp deadbeef", mem_rdata); end
        checks++; if (dmem_read !== 1'b0) begin errors++;
            $display("FAIL lw_req_drop: got %b exp 0", dmem_read); end
        advance();
    endtask

    task automatic test_lb_lbu();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011};
        for (int i = 0; i < 4; i++) begin
            run(1'b1, 1'b0, f3s[i], as[i], 32'd0, 32'h80112233, 1);
            checks++; if (mem_rdata !== exp[i] || stalls !== 2) begin errors++;
                $display("FAIL load_ext[%0d]: got %h stalls=%0d exp %h stalls=2",
                         i, mem_rdata, stalls, exp[i]); end
            checks++; if (s_addr !== {as[i][31:2], 2'b00}) begin errors++;
                $display("FAIL load_addr[%0d]: got %h exp %h", i, s_addr, {as[i][31:2], 2'b00}); end
            advance();
        end
    endtask

    task automatic test_sh();
        logic [2:0]  f3s [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] as  [3] = '{32'h206, 32'h201, 32'h20C};
        logic [31:0] wds [3] = '{32'h1234ABCD, 32'h000000A5, 32'h01234567};
        logic [31:0] ea  [3] = '{32'h204, 32'h200, 32'h20C};
        logic [3:0]  eb  [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ew  [3] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'h01234567};
        for (int i = 0; i < 3; i++) begin
            run(1'b0, 1'b1, f3s[i], as[i], wds[i], 32'h55555555, 2);
            checks++; if (s_wr !== 1'b1 || s_rd !== 1'b0 || s_addr !== ea[i]) begin errors++;
                $display("FAIL store_req[%0d]: got wr=%b rd=%b addr=%h exp 1 0 %h",
                         i, s_wr, s_rd, s_addr, ea[i]); end
            checks++; if (s_be !== eb[i] || s_wdata !== ew[i]) begin errors++;
                $display("FAIL store_lanes[%0d]: got be=%b wd=%h exp %b %h",
                         i, s_be, s_wdata, eb[i], ew[i]); end
            checks++; if (mem_rdata !== 32'h00008011) begin errors++;
                $display("FAIL store_rdata_kept[%0d]: got %h exp 00008011", i, mem_rdata); end
            advance();
        end
        run(1'b1, 1'b1, 3'b010, 32'h210, 32'hCAFE0001, 32'h77777777, 1);
        checks++; if (s_wr !== 1'b1 || s_rd !== 1'b0 || mem_rdata !== 32'h00008011) begin errors++;
            $display("FAIL rd_wr_both: got wr=%b rd=%b rdata=%h exp 1 0 00008011",
                     s_wr, s_rd, mem_rdata); end
        advance();
    endtask

    task automatic test_hold();
        int bad_cycles;
        run(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h0BADF00D, 1);
        bad_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            dmem_resp = c[0];
            dmem_rdata = 32'h11111111;
            #1;
            if (mem_stall !== 1'b0 || (dmem_read | dmem_write) !== 1'b0 ||
                mem_rdata !== 32'h0BADF00D) bad_cycles++;
            tick();
        end
        dmem_resp = 1'b0;
        #1;
        checks++; if (bad_cycles !== 0 || mem_rdata !== 32'h0BADF00D) begin errors++;
            $display("FAIL hold_stable: got bad=%0d rdata=%h exp 0 0badf00d", bad_cycles, mem_rdata); end
        checks++; if (reqs !== 1) begin errors++;
            $display("FAIL hold_one_req: got %0d exp 1", reqs); end
        advance();
        checks++; if (mem_stall !== 1'b0 || mem_rdata !== 32'h0BADF00D) begin errors++;
            $display("FAIL hold_release: got stall=%b rdata=%h exp 0 0badf00d", mem_stall, mem_rdata); end
    endtask

    task automatic test_back_to_back();
        run(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 32'hCAFEBABE, 1);
        pipe_advance = 1'b1;
        ex_addr = 32'h404;
        #1;
        checks++; if (mem_stall !== 1'b0 || mem_rdata !== 32'hCAFEBABE) begin errors++;
            $display("FAIL b2b_first: got stall=%b rdata=%h exp 0 cafebabe", mem_stall, mem_rdata); end
        tick();
        run(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, 32'h01020304, 1);
        checks++; if (stalls !== 2 || mem_rdata !== 32'h01020304 || s_addr !== 32'h404) begin errors++;
            $display("FAIL b2b_second: got stalls=%0d rdata=%h addr=%h exp 2 01020304 404",
                     stalls, mem_rdata, s_addr); end
        advance();
    endtask

    task automatic test_misalign();
        run(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'h89ABCDEF, 1);
`ifdef MEM_MISALIGN_CHECK_EN
        checks++; if (reqs !== 0 || stalls !== 1) begin errors++;
            $display("FAIL mis_noreq: got reqs=%0d stalls=%0d exp 0 1", reqs, stalls); end
        checks++; if (misalign !== 1'b1 || mem_rdata !== 32'd0) begin errors++;
            $display("FAIL mis_flag: got mis=%b rdata=%h exp 1 0", misalign, mem_rdata); end
        advance();
        checks++; if (misalign !== 1'b0) begin errors++;
            $display("FAIL mis_clear: got %b exp 0", misalign); end
`else
        checks++; if (reqs !== 1 || stalls !== 2 || s_addr !== 32'h100) begin errors++;
            $display("FAIL unal_lw: got reqs=%0d stalls=%0d addr=%h exp 1 2 100", reqs, stalls, s_addr); end
        checks++; if (misalign !== 1'b0 || mem_rdata !== 32'h89ABCDEF) begin errors++;
            $display("FAIL unal_lw_data: got mis=%b rdata=%h exp 0 89abcdef", misalign, mem_rdata); end
        advance();
        run(1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 32'h1234F678, 1);
        checks++; if (mem_rdata !== 32'hFFFFF678 || misalign !== 1'b0) begin errors++;
            $display("FAIL unal_lh: got rdata=%h mis=%b exp fffff678 0", mem_rdata, misalign); end
        advance();
`endif
    endtask

    task automatic test_reset_busy();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h500;
        #1;
        tick();
        checks++; if (dmem_read !== 1'b1 || mem_stall !== 1'b1) begin errors++;
            $display("FAIL rb_busy: got rd=%b stall=%b exp 1 1", dmem_read, mem_stall); end
        reset = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (dmem_read !== 1'b0 || mem_stall !== 1'b0 || mem_rdata !== 32'd0) begin errors++;
            $display("FAIL rb_after: got rd=%b stall=%b rdata=%h exp 0 0 0",
                     dmem_read, mem_stall, mem_rdata); end
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        tick();
        dmem_resp = 1'b0;
        #1;
        checks++; if (mem_rdata !== 32'd0 || mem_stall !== 1'b0 || dmem_read !== 1'b0) begin errors++;
            $display("FAIL rb_late_resp: got rdata=%h stall=%b rd=%b exp 0 0 0",
                     mem_rdata, mem_stall, dmem_read); end
        run(1'b1, 1'b0, 3'b100, 32'h501, 32'd0, 32'h0000AB00, 1);
        checks++; if (mem_rdata !== 32'h000000AB || stalls !== 2) begin errors++;
            $display("FAIL rb_recover: got rdata=%h stalls=%0d exp 000000ab 2", mem_rdata, stalls); end
        advance();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_hold();
        test_back_to_back();
        test_misalign();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit for the pipelined RV32I core. It takes the load/store held in the EX/MEM register, issues a word-aligned request to the data cache, and stalls the pipeline until the cache responds. It then presents byte-aligned, sign- or zero-extended load data on `mem_rdata`, which drives the `MEM_rdata` input of the MEM/WB pipeline register. It is the producer side of the load data that the writeback stage consumes.

## Interface
Parameters: none.

Clocking and reset: reset reset, synchronous, active-high; clock clk.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  MEM stage holds a valid instruction
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  in  32  effective byte address (ALU result)
- ex_wdata  in  32  store data (rs2)
- pipe_advance  in  1  global pipeline load taken this cycle
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_address  out  32  `{addr[31:2],2'b00}`
- dmem_wdata  out  32  lane-replicated store data
- dmem_byte_enable  out  4  store lane mask
- dmem_resp  in  1  cache response, one-cycle pulse
- dmem_rdata  in  32  cache read word, valid with `dmem_resp`
- mem_stall  out  1  MEM stage not ready; freezes all pipeline registers
- mem_rdata  out  32  extended load data to MEM/WB
- misalign  out  1  misaligned access flag

## Operation
- The FSM has three states: IDLE, BUSY and HOLD.
- IDLE:
  - If `ex_valid & (ex_mem_read|ex_mem_write)`: latch the request (kind, address, lanes, wdata, funct3, `addr[1:0]`), assert `mem_stall`, go to BUSY.
  - Otherwise `mem_stall=0` and the state stays IDLE.
  - If read and write are both set, treat the access as a write.
- BUSY:
  - `dmem_read`/`dmem_write` come from registered state and are held stable with address, data and lanes until `dmem_resp`.
  - `mem_stall=1`, including on the response cycle.
  - On `dmem_resp`: register the extended load data into `mem_rdata` (loads only; stores leave it unchanged), drop the request, go to HOLD.
- HOLD:
  - `mem_stall=0` and there is no request.
  - On `pipe_advance`, go to IDLE; otherwise stay in HOLD. There is no re-issue while another stage stalls.
- Store lanes:
  - SB: `be=4'b0001<<addr[1:0]`, data byte replicated ×4.
  - SH: `be=4'b0011<<{addr[1],1'b0}`, data half replicated ×2.
  - SW: `be=4'b1111`.
- Load extraction:
  - B/BU select the byte `addr[1:0]`.
  - H/HU select the half `addr[1]`.
  - W takes the whole word.
  - B and H sign-extend; BU and HU zero-extend.
  - Undefined funct3 values are treated as W.
- Address width: `dmem_address` always has bits [1:0] forced to 0.
- A `dmem_resp` seen while in IDLE or HOLD is ignored.

## Timing
- Reset values: state IDLE; `dmem_read`, `dmem_write`, `dmem_byte_enable`, `misalign` = 0; `dmem_address`, `dmem_wdata`, `mem_rdata` = 0.
- Request cycle N (IDLE): `mem_stall=1`. From N+1, `dmem_read`/`dmem_write` are high.
- Response at cycle M ≥ N+1: `mem_rdata` is valid from M+1 and `mem_stall` falls at M+1, so MEM/WB loads at the end of M+1.
- Minimum load/store occupancy is 3 cycles (N, N+1 response, N+2 release).
- Back-to-back memory instructions cost one extra IDLE cycle each.
- Reset mid-BUSY: the request drops on the next cycle, and a late `dmem_resp` is ignored.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]≠0`, issue no cache request.
  - IDLE goes directly to HOLD with `misalign=1` and `mem_rdata=0`, stalling for only the one request cycle.
  - `misalign` clears on leaving HOLD.
- Undefined:
  - `misalign` is tied to 0.
  - H accesses use `addr[1]` only, W accesses ignore `addr[1:0]`, and all accesses proceed normally.

## Test plan
- LW at 0x100, cache `rdata=0xDEADBEEF`, `resp` 3 cycles after request -> `dmem_address=0x100`, `mem_stall` high for 4 cycles, `mem_rdata=0xDEADBEEF`.
- LB at 0x103 and LBU at 0x103 with `rdata=0x80112233` -> `mem_rdata` is 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x206, `wdata=0x1234ABCD` -> `dmem_write=1`, `address=0x204`, `be=4'b1100`, `wdata=0xABCDABCD`; `mem_rdata` unchanged.
- Response arrives while `pipe_advance=0` for 5 cycles -> HOLD with `mem_stall=0`, exactly one request issued, `mem_rdata` stable until advance.
- Reset asserted in BUSY, then `dmem_resp` 2 cycles later -> `dmem_read=0` after one edge, state IDLE, `mem_rdata=0`, response ignored.
- With `MEM_MISALIGN_CHECK_EN`, LW at 0x102 -> no `dmem_read`, `misalign=1`, `mem_rdata=0`, `mem_stall` high for exactly 1 cycle.
